// File: rtl/i2s_rx_deframer.sv
// I2S receive deframer: turns the codec's serial ADC stream into signed
// PCM words. It holds one left and one right word, each with a one-cycle
// update strobe, plus a mono copy of the selected channel for the echo
// stage. It also tracks short slots (sticky) and the slot length in sck
// cycles for bring-up debug. All logic runs on the rising edge of sck.
module i2s_rx_deframer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_SEL = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  sck,
    input  logic                  rst_n,
    input  logic                  lrck,
    input  logic                  sdin,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  left_vld,
    output logic                  right_vld,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  short_err,
    output logic [CNT_WIDTH-1:0]  slot_len
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ZERO = BIT_CNT_W'(0);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] SLOT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SLOT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic                 SEL_CHAN = (CHANNEL_SEL != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
    localparam logic [1:0] ST_CAPTURE   = 2'd1;
    localparam logic [1:0] ST_SKIP      = 2'd2;

    // Edge detection and sync tracking
    logic                  lrck_d_r;
    logic                  primed_r;
    logic                  sync_seen_r;
    logic                  raw_edge_s;
    logic                  ws_edge_s;

    // Framing FSM
    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic                  chan_r;
    logic                  chan_nxt_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_nxt_s;
    logic                  shift_s;
    logic                  word_done_s;
    logic                  short_hit_s;
    logic                  sync_hit_s;

    // Data path and status
    logic [DATA_WIDTH-2:0] shreg_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic [DATA_WIDTH-1:0] left_data_r;
    logic [DATA_WIDTH-1:0] right_data_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  left_vld_r;
    logic                  right_vld_r;
    logic                  short_err_r;
    logic [CNT_WIDTH-1:0]  slot_cnt_r;
    logic [CNT_WIDTH-1:0]  slot_len_r;

    // primed_r keeps the reset value of lrck_d_r from faking an edge on the
    // first cycle after reset, whatever level lrck happens to be at.
    assign raw_edge_s = primed_r && (lrck != lrck_d_r);
    assign ws_edge_s  = raw_edge_s && sync_seen_r;
    assign word_s     = {shreg_r, sdin};

    assign left_data  = left_data_r;
    assign right_data = right_data_r;
    assign left_vld   = left_vld_r;
    assign right_vld  = right_vld_r;
    assign data_out   = data_out_r;
    assign short_err  = short_err_r;
    assign slot_len   = slot_len_r;

    // Next-state logic: sync on the first edge, capture DATA_WIDTH bits, then skip padding
    always_comb begin
        state_nxt_s   = state_r;
        chan_nxt_s    = chan_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_s       = 1'b0;
        word_done_s   = 1'b0;
        short_hit_s   = 1'b0;
        sync_hit_s    = 1'b0;
        case (state_r)
            ST_WAIT_SYNC: begin
                if (raw_edge_s) begin
                    state_nxt_s   = ST_CAPTURE;
                    chan_nxt_s    = lrck;
                    bit_cnt_nxt_s = BIT_ZERO;
                    sync_hit_s    = 1'b1;
                end else begin
                    state_nxt_s   = ST_WAIT_SYNC;
                end
            end
            ST_CAPTURE: begin
                if (ws_edge_s) begin
                    // Slot ended early: drop the partial word, flag it.
                    state_nxt_s   = ST_CAPTURE;
                    chan_nxt_s    = lrck;
                    bit_cnt_nxt_s = BIT_ZERO;
                    short_hit_s   = 1'b1;
                end else if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s   = ST_SKIP;
                    word_done_s   = 1'b1;
                end else begin
                    shift_s       = 1'b1;
                    bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
                end
            end
            ST_SKIP: begin
                if (ws_edge_s) begin
                    state_nxt_s   = ST_CAPTURE;
                    chan_nxt_s    = lrck;
                    bit_cnt_nxt_s = BIT_ZERO;
                end else begin
                    state_nxt_s   = ST_SKIP;
                end
            end
            default: begin
                state_nxt_s   = ST_WAIT_SYNC;
                bit_cnt_nxt_s = BIT_ZERO;
            end
        endcase
    end

    // Word-select history and one-time sync flag
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            lrck_d_r    <= 1'b0;
            primed_r    <= 1'b0;
            sync_seen_r <= 1'b0;
        end else begin
            lrck_d_r    <= lrck;
            primed_r    <= 1'b1;
            sync_seen_r <= sync_seen_r | sync_hit_s;
        end
    end

    // FSM state, channel of the slot being captured and bit position
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_WAIT_SYNC;
            chan_r    <= 1'b0;
            bit_cnt_r <= BIT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            chan_r    <= chan_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    // MSB-first shift register holding all but the final bit of a word
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
        end else if (shift_s) begin
            shreg_r <= word_s[DATA_WIDTH-2:0];
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Completed-word registers and their one-cycle strobes
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            left_data_r  <= '0;
            right_data_r <= '0;
            data_out_r   <= '0;
            left_vld_r   <= 1'b0;
            right_vld_r  <= 1'b0;
        end else begin
            left_vld_r  <= word_done_s && !chan_r;
            right_vld_r <= word_done_s && chan_r;
            if (word_done_s && !chan_r) begin
                left_data_r <= word_s;
            end else begin
                left_data_r <= left_data_r;
            end
            if (word_done_s && chan_r) begin
                right_data_r <= word_s;
            end else begin
                right_data_r <= right_data_r;
            end
            if (word_done_s && (chan_r == SEL_CHAN)) begin
                data_out_r <= word_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    // Debug status: sticky short-slot flag and saturating slot-length counter
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            short_err_r <= 1'b0;
            slot_cnt_r  <= '0;
            slot_len_r  <= '0;
        end else begin
            short_err_r <= short_err_r | short_hit_s;
            if (raw_edge_s) begin
                slot_cnt_r <= SLOT_ONE;
            end else if (sync_seen_r && (slot_cnt_r != SLOT_MAX)) begin
                slot_cnt_r <= slot_cnt_r + SLOT_ONE;
            end else begin
                slot_cnt_r <= slot_cnt_r;
            end
            if (ws_edge_s) begin
                slot_len_r <= slot_cnt_r;
            end else begin
                slot_len_r <= slot_len_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deframer.sv
// Bench for i2s_rx_deframer: a table of I2S slots is driven one sck cycle at
// a time. Each slot's expected word is queued as the LSB is sent and is
// matched against the valid strobes by a monitor on the falling edge.
module tb_i2s_rx_deframer;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam logic SEL = 1'b0;

    logic          sck   = 1'b0;
    logic          rst_n = 1'b0;
    logic          lrck  = 1'b0;
    logic          sdin  = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          left_vld;
    logic          right_vld;
    logic [DW-1:0] data_out;
    logic          short_err;
    logic [CW-1:0] slot_len;

    i2s_rx_deframer #(.DATA_WIDTH(DW), .CHANNEL_SEL(0), .CNT_WIDTH(CW)) dut (
        .sck(sck), .rst_n(rst_n), .lrck(lrck), .sdin(sdin),
        .left_data(left_data), .right_data(right_data),
        .left_vld(left_vld), .right_vld(right_vld),
        .data_out(data_out), .short_err(short_err), .slot_len(slot_len)
    );

    always #5 sck = ~sck;

    // One slot: lrck level, word, length in sck cycles (edge cycle included),
    // pad style, whether a word is expected, and the short_err / slot_len
    // values expected one cycle after the slot's opening edge (-1 = skip).
    typedef struct {
        logic          ch;
        logic [DW-1:0] word;
        int            len;
        logic          pad;
        logic          exp_vld;
        logic          exp_short;
        int            exp_len;
    } row_t;

    typedef struct {
        logic          ch;
        logic [DW-1:0] word;
    } exp_t;

    row_t          rows_a[$];
    row_t          rows_c[$];
    row_t          rows_b[$];
    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            n_left = 0;
    int            n_right = 0;
    int            snap_left;
    int            snap_right;
    logic [DW-1:0] exp_left = '0;
    logic [DW-1:0] exp_right = '0;
    logic [DW-1:0] exp_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic ch, input logic [DW-1:0] w, input int len,
                                input logic pad, input logic v, input logic s, input int l);
        row_t r;
        r.ch = ch; r.word = w; r.len = len; r.pad = pad;
        r.exp_vld = v; r.exp_short = s; r.exp_len = l;
        return r;
    endfunction

    task automatic apply_row(input row_t r);
        exp_t e;
        for (int i = 0; i < r.len; i++) begin
            @(negedge sck);
            if (i == 1) begin
                check("short_err", 32'(short_err), 32'(r.exp_short));
                if (r.exp_len >= 0) check("slot_len", 32'(slot_len), 32'(r.exp_len));
            end
            lrck = r.ch;
            sdin = (i >= 1 && i <= DW) ? r.word[DW - i] : (r.pad & i[0]);
            if (i == DW && r.exp_vld) begin
                e.ch = r.ch;
                e.word = r.word;
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: strobes pop the scoreboard; held words are compared every cycle
    always @(negedge sck) begin
        check("vld_exclusive", 32'(left_vld & right_vld), 32'd0);
        if (left_vld) n_left++;
        if (right_vld) n_right++;
        if (left_vld || right_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", {30'd0, left_vld, right_vld}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("vld_chan", 32'(right_vld), 32'(mon_e.ch));
                if (mon_e.ch) exp_right = mon_e.word;
                else exp_left = mon_e.word;
                if (mon_e.ch == SEL) exp_dout = mon_e.word;
            end
        end
        check("left_data", 32'(left_data), 32'(exp_left));
        check("right_data", 32'(right_data), 32'(exp_right));
        check("data_out", 32'(data_out), 32'(exp_dout));
    end

    initial begin
        // Partial right slot before sync, then nominal 32-cycle slots and a saturating slot
        rows_a.push_back(mk(1'b1, 16'h0155, 10,  1'b1, 1'b0, 1'b0, 0));
        rows_a.push_back(mk(1'b0, 16'h1234, 32,  1'b0, 1'b1, 1'b0, 0));
        rows_a.push_back(mk(1'b1, 16'h0F0F, 32,  1'b0, 1'b1, 1'b0, 32));
        rows_a.push_back(mk(1'b0, 16'h8001, 32,  1'b0, 1'b1, 1'b0, 32));
        rows_a.push_back(mk(1'b1, 16'h7FFE, 32,  1'b0, 1'b1, 1'b0, 32));
        rows_a.push_back(mk(1'b0, 16'hC3A5, 300, 1'b1, 1'b1, 1'b0, 32));
        // Short slot, recovery, every-cycle lrck toggling, recovery
        rows_c.push_back(mk(1'b1, 16'h1111, 12,  1'b1, 1'b0, 1'b0, 17));
        rows_c.push_back(mk(1'b0, 16'h4321, 17,  1'b0, 1'b1, 1'b1, 12));
        rows_c.push_back(mk(1'b1, 16'h2468, 20,  1'b1, 1'b1, 1'b1, 17));
        rows_c.push_back(mk(1'b0, 16'hFFFF, 1,   1'b0, 1'b0, 1'b1, -1));
        rows_c.push_back(mk(1'b1, 16'hFFFF, 1,   1'b0, 1'b0, 1'b1, -1));
        rows_c.push_back(mk(1'b0, 16'hFFFF, 1,   1'b0, 1'b0, 1'b1, -1));
        rows_c.push_back(mk(1'b1, 16'hFFFF, 1,   1'b0, 1'b0, 1'b1, -1));
        rows_c.push_back(mk(1'b0, 16'h9999, 17,  1'b0, 1'b1, 1'b1, 1));
        rows_c.push_back(mk(1'b1, 16'h0001, 17,  1'b0, 1'b1, 1'b1, 17));
        // After the mid-slot reset: unsynced right slot, then a full frame
        rows_b.push_back(mk(1'b1, 16'h7777, 17,  1'b0, 1'b0, 1'b0, 0));
        rows_b.push_back(mk(1'b0, 16'h5A5A, 17,  1'b0, 1'b1, 1'b0, 0));
        rows_b.push_back(mk(1'b1, 16'hA5A5, 17,  1'b1, 1'b1, 1'b0, 17));

        // Reset with random inputs: everything stays zero
        for (int i = 0; i < 5; i++) begin
            @(negedge sck);
            check("rst_vld", {30'd0, left_vld, right_vld}, 32'd0);
            check("rst_short", 32'(short_err), 32'd0);
            check("rst_slot_len", 32'(slot_len), 32'd0);
            lrck = 1'($urandom_range(0, 1));
            sdin = 1'($urandom_range(0, 1));
        end
        @(negedge sck);
        lrck = 1'b1;
        sdin = 1'b0;
        #2 rst_n = 1'b1;

        foreach (rows_a[j]) apply_row(rows_a[j]);

        // 100 exact-fit frames (edge cycle + 16 data bits per slot)
        snap_left = n_left;
        snap_right = n_right;
        for (int k = 0; k < 200; k++) begin
            apply_row(mk((k % 2 == 0) ? 1'b1 : 1'b0, (k % 2 == 0) ? 16'h5555 : 16'hAAAA,
                         17, 1'b0, 1'b1, 1'b0, (k == 0) ? 255 : 17));
        end

        foreach (rows_c[j]) begin
            apply_row(rows_c[j]);
            if (j == 0) begin
                check("exact_fit_left_pulses", 32'(n_left - snap_left), 32'd100);
                check("exact_fit_right_pulses", 32'(n_right - snap_right), 32'd100);
            end
        end

        // Reset at bit 7 of a left slot: outputs clear at once
        for (int i = 0; i < 8; i++) begin
            @(negedge sck);
            lrck = 1'b0;
            sdin = (i >= 1) ? ((16'hBEEF >> (DW - i)) & 16'h0001) != 16'h0000 : 1'b0;
        end
        @(negedge sck);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_left = '0;
        exp_right = '0;
        exp_dout = '0;
        #1;
        check("midrst_left", 32'(left_data), 32'd0);
        check("midrst_right", 32'(right_data), 32'd0);
        check("midrst_dout", 32'(data_out), 32'd0);
        check("midrst_short", 32'(short_err), 32'd0);
        check("midrst_slot_len", 32'(slot_len), 32'd0);
        repeat (3) @(negedge sck);
        lrck = 1'b1;
        sdin = 1'b0;
        #2 rst_n = 1'b1;

        foreach (rows_b[j]) apply_row(rows_b[j]);

        repeat (3) @(negedge sck);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_left", 32'(left_data), 32'h5A5A);
        check("final_right", 32'(right_data), 32'hA5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
